// File: rtl/cpu_memory.sv
`default_nettype none
// ============================================================================
// Module      : cpu_memory
// Description : Memory stage of the CPU pipeline. Forwards execute results to
//               write-back and performs byte/short/long loads and stores on a
//               single-outstanding data bus with big-endian lane mapping,
//               misalignment detection and an ack timeout.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, rst_i                 clock; asynchronous active-high reset
//   mem_op_i[2:0]                000/100 none, 001/010/011 ld.b/s/l,
//                                101/110/111 st.b/s/l
//   result_i[31:0]               execute result / effective address
//   store_data_i[31:0]           right-justified store data
//   register_write_enable_i      execute write enable
//   register_write_index_i[3:0]  destination register
//   register_write_enable_o      registered write-back enable
//   register_write_index_o[3:0]  registered write-back index
//   result_o[31:0]               registered write-back data
//   stall_o                      combinational hold request upstream
//   dmem_*_o                     registered data-bus request
//   dmem_dat_i, dmem_ack_i       data-bus returns
//   misalign_o, bus_error_o      one-cycle fault pulses
// ============================================================================
module cpu_memory #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  mem_op_i,
  input  logic [31:0] result_i,
  input  logic [31:0] store_data_i,
  input  logic        register_write_enable_i,
  input  logic [3:0]  register_write_index_i,
  output logic        register_write_enable_o,
  output logic [3:0]  register_write_index_o,
  output logic [31:0] result_o,
  output logic        stall_o,
  output logic [31:0] dmem_adr_o,
  output logic [31:0] dmem_dat_o,
  output logic [3:0]  dmem_sel_o,
  output logic        dmem_we_o,
  output logic        dmem_cyc_o,
  output logic        dmem_stb_o,
  input  logic [31:0] dmem_dat_i,
  input  logic        dmem_ack_i,
  output logic        misalign_o,
  output logic        bus_error_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  // Counter value of the last BUS cycle allowed before the access is aborted.
  localparam logic [7:0] c_timeout_last = 8'(ACK_TIMEOUT - 1);

  state_t      r_state, w_state_next;
  logic [7:0]  r_cnt, w_cnt_next;

  logic        w_is_mem, w_misaligned, w_stall;
  logic [3:0]  w_sel;
  logic [31:0] w_store_lanes, w_load_lane;

  logic        w_wen_next, w_misalign_next, w_berr_next;
  logic [3:0]  w_widx_next, w_sel_next;
  logic [31:0] w_result_next, w_adr_next, w_dat_next;
  logic        w_we_next, w_cyc_next, w_stb_next;

  // Size lives in mem_op_i[1:0]; 00 means no memory access regardless of bit 2.
  assign w_is_mem     = (mem_op_i[1:0] != 2'b00);
  assign w_misaligned = ((mem_op_i[1:0] == 2'b10) && result_i[0]) ||
                        ((mem_op_i[1:0] == 2'b11) && (result_i[1:0] != 2'b00));

  // Big-endian lane select and store replication for the op in IDLE.
  always_comb begin
    w_sel         = 4'b1111;
    w_store_lanes = store_data_i;
    case (mem_op_i[1:0])
      2'b01: begin
        w_sel         = 4'b1000 >> result_i[1:0];
        w_store_lanes = {4{store_data_i[7:0]}};
      end
      2'b10: begin
        w_sel         = result_i[1] ? 4'b0011 : 4'b1100;
        w_store_lanes = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // The registered byte select fully describes size and offset of the
  // outstanding load, so no separate copy of the op is kept.
  always_comb begin
    w_load_lane = dmem_dat_i;
    case (dmem_sel_o)
      4'b1000: w_load_lane = {24'h0, dmem_dat_i[31:24]};
      4'b0100: w_load_lane = {24'h0, dmem_dat_i[23:16]};
      4'b0010: w_load_lane = {24'h0, dmem_dat_i[15:8]};
      4'b0001: w_load_lane = {24'h0, dmem_dat_i[7:0]};
      4'b1100: w_load_lane = {16'h0, dmem_dat_i[31:16]};
      4'b0011: w_load_lane = {16'h0, dmem_dat_i[15:0]};
      default: ;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_stall         = 1'b0;
    w_wen_next      = 1'b0;
    w_widx_next     = register_write_index_o;
    w_result_next   = result_o;
    w_misalign_next = 1'b0;
    w_berr_next     = 1'b0;
    w_adr_next      = dmem_adr_o;
    w_dat_next      = dmem_dat_o;
    w_sel_next      = dmem_sel_o;
    w_we_next       = dmem_we_o;
    w_cyc_next      = dmem_cyc_o;
    w_stb_next      = dmem_stb_o;
    case (r_state)
      ST_IDLE: begin
        if (!w_is_mem) begin
          w_result_next = result_i;
          w_wen_next    = register_write_enable_i;
          w_widx_next   = register_write_index_i;
        end else if (w_misaligned) begin
          w_misalign_next = 1'b1;
        end else begin
          w_stall      = 1'b1;
          w_state_next = ST_BUS;
          w_cnt_next   = 8'd0;
          w_adr_next   = {result_i[31:2], 2'b00};
          w_dat_next   = w_store_lanes;
          w_sel_next   = w_sel;
          w_we_next    = mem_op_i[2];
          w_cyc_next   = 1'b1;
          w_stb_next   = 1'b1;
        end
      end
      ST_BUS: begin
        // Ack is checked first so it wins over a timeout in the same cycle.
        if (dmem_ack_i) begin
          w_state_next = ST_IDLE;
          w_cyc_next   = 1'b0;
          w_stb_next   = 1'b0;
          w_we_next    = 1'b0;
          if (!dmem_we_o) begin
            w_result_next = w_load_lane;
            w_wen_next    = 1'b1;
            w_widx_next   = register_write_index_i;
          end
        end else begin
          w_stall = 1'b1;
          if (r_cnt == c_timeout_last) begin
            w_state_next = ST_IDLE;
            w_cyc_next   = 1'b0;
            w_stb_next   = 1'b0;
            w_we_next    = 1'b0;
            w_berr_next  = 1'b1;
          end else begin
            w_cnt_next = r_cnt + 8'd1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Reset gates the stall so upstream is released while reset is held.
  assign stall_o = w_stall & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state                 <= ST_IDLE;
      r_cnt                   <= 8'd0;
      register_write_enable_o <= 1'b0;
      register_write_index_o  <= 4'd0;
      result_o                <= 32'd0;
      misalign_o              <= 1'b0;
      bus_error_o             <= 1'b0;
      dmem_adr_o              <= 32'd0;
      dmem_dat_o              <= 32'd0;
      dmem_sel_o              <= 4'd0;
      dmem_we_o               <= 1'b0;
      dmem_cyc_o              <= 1'b0;
      dmem_stb_o              <= 1'b0;
    end else begin
      r_state                 <= w_state_next;
      r_cnt                   <= w_cnt_next;
      register_write_enable_o <= w_wen_next;
      register_write_index_o  <= w_widx_next;
      result_o                <= w_result_next;
      misalign_o              <= w_misalign_next;
      bus_error_o             <= w_berr_next;
      dmem_adr_o              <= w_adr_next;
      dmem_dat_o              <= w_dat_next;
      dmem_sel_o              <= w_sel_next;
      dmem_we_o               <= w_we_next;
      dmem_cyc_o              <= w_cyc_next;
      dmem_stb_o              <= w_stb_next;
    end
  end

endmodule
`default_nettype wire

// File: doc/cpu_memory.md
CPU_MEMORY -- requirements
Module: cpu_memory

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 15, the number of BUS-state cycles without dmem_ack_i before the access is aborted; legal range 1..255.
REQ-002 SHALL have port clk_i  in  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port mem_op_i  in  3  memory operation from execute: 000 none, 001 ld.b, 010 ld.s, 011 ld.l, 101 st.b, 110 st.s, 111 st.l, 100 treated as none.
REQ-005 SHALL have port result_i  in  32  execute result; effective address when mem_op_i is non-none.
REQ-006 SHALL have port store_data_i  in  32  store data, right-justified.
REQ-007 SHALL have port register_write_enable_i  in  1  execute write enable.
REQ-008 SHALL have port register_write_index_i  in  4  destination register.
REQ-009 SHALL have ports register_write_enable_o (1), register_write_index_o (4), result_o (32), all out, registered write-back outputs.
REQ-010 SHALL have port stall_o  out  1  combinational hold request to upstream stages.
REQ-011 SHALL have ports dmem_adr_o (32), dmem_dat_o (32), dmem_sel_o (4), dmem_we_o (1), dmem_cyc_o (1), dmem_stb_o (1), all out, registered data bus.
REQ-012 SHALL have ports dmem_dat_i (32) and dmem_ack_i (1), both in, data bus returns.
REQ-013 SHALL have ports misalign_o (1) and bus_error_o (1), both out, one-cycle registered fault pulses.

Function
REQ-014 SHALL implement two states, IDLE and BUS.
REQ-015 SHALL, in IDLE with mem_op_i none, register result_i, register_write_enable_i and register_write_index_i to the outputs on the next edge; pass-through latency 1 cycle.
REQ-016 SHALL treat ld.s/st.s with address bit 0 set and ld.l/st.l with address bits 1:0 non-zero as misaligned: no bus cycle, misalign_o pulses 1 cycle, register_write_enable_o 0, state stays IDLE, stall_o 0.
REQ-017 SHALL, in IDLE with an aligned memory op, assert stall_o that cycle and on the edge enter BUS with dmem_cyc_o = dmem_stb_o = 1, dmem_adr_o = result_i with bits 1:0 cleared, dmem_we_o = 1 for stores, and register_write_enable_o = 0.
REQ-018 SHALL use big-endian lanes: byte offset 0..3 maps to sel 1000/0100/0010/0001 and bits 31:24..7:0; short offset 0/2 maps to sel 1100/0011; long sel 1111; store data replicated onto the selected lane(s).
REQ-019 SHALL hold stall_o = 1 in BUS while dmem_ack_i = 0 and drop it combinationally in the cycle dmem_ack_i = 1.
REQ-020 SHALL, on an edge with BUS and dmem_ack_i = 1, deassert cyc/stb/we, return to IDLE, and for loads set result_o to the selected lane zero-extended to 32 bits with register_write_enable_o = 1 and index from register_write_index_i; for stores register_write_enable_o = 0.
REQ-021 SHALL give minimum load latency of 2 cycles from op presentation to write-back valid (ack in first BUS cycle).
REQ-022 SHALL count BUS cycles in an 8-bit counter cleared on BUS entry; when ACK_TIMEOUT cycles elapse without ack, drop cyc/stb, pulse bus_error_o 1 cycle, write nothing, return to IDLE.
REQ-023 SHALL give dmem_ack_i priority over timeout in the same cycle.
REQ-024 SHALL ignore dmem_ack_i while in IDLE.
REQ-025 SHALL hold register_write_enable_o = 0 on every edge spent in BUS without ack.

Reset
REQ-026 SHALL on rst_i immediately force state IDLE, counter 0, and all outputs 0, including dmem_cyc_o/dmem_stb_o mid-access; stall_o then 0.
REQ-027 SHALL begin normal operation on the first rising edge after rst_i deasserts.

Verification
REQ-028 Pass-through: mem_op_i 000, result_i 0x12345678, enable 1, index 3 -> next cycle result_o 0x12345678, enable 1, index 3, stall_o 0, no bus cycle.
REQ-029 ld.b at 0x1001, ack after 2 BUS cycles with dmem_dat_i 0xAABBCCDD -> adr 0x1000, sel 0100, stall_o 1 for 3 cycles, result_o 0x000000BB, enable 1.
REQ-030 st.s at 0x2002, store_data_i 0x0000BEEF, immediate ack -> adr 0x2000, sel 0011, dat_o 0xBEEFBEEF, we 1, enable_o 0, total 2 cycles.
REQ-031 ld.l at 0x3002 -> misalign_o 1 for one cycle, no cyc, enable_o 0, stall_o 0.
REQ-032 ld.l with no ack, ACK_TIMEOUT 15 -> cyc high 15 cycles, bus_error_o pulse, enable_o 0, state IDLE; a subsequent pass-through op completes normally.
REQ-033 rst_i asserted in BUS cycle 2 -> cyc/stb/stall_o drop without waiting for a clock edge; no write-back after release.
